alu_flags_register: RTL and testbench
=====================================

// Module: alu_flags_register
// PURPOSE
// Architectural flags register directly downstream of the ALU. Captures the five
// ALU flags on ALU operations, supplies the shift carry-in back to the ALU, can be
// loaded from or asserted onto MainBus, and keeps a small LIFO of saved flags for
// interrupt entry/exit. It also evaluates the branch condition for the jump stage.
// PARAMETERS
// STACK_DEPTH  4  saved-flags LIFO entries (power of two, >=2)
// PTR_W        2  log2(STACK_DEPTH)
// PORTS
// Clock         in     1  system clock, all state on rising edge
// Reset         in     1  asynchronous, active-low; clears all state
// AluActive     in     1  high: capture FlagsIn this cycle (ALU op executing)
// FlagsIn       in     5  {CarryL,CarryA,Zero,Sign,Overflow} from ALU flag outputs
// MainBus       inout  8  shared bus; bits[4:0] carry flags
// Flags_Load    in     1  active-low: load flags from MainBus[4:0]
// Flags_Assert  in     1  active-low: drive {3'b000,Flags} onto MainBus
// Flags_Push    in     1  high: push Flags onto LIFO
// Flags_Pop     in     1  high: pop LIFO top into Flags
// CondSel       in     3  branch condition select
// Flags         out    5  current flags, same bit order as FlagsIn
// LCarryIn      out    1  = Flags[4] (CarryL), shift carry-in to ALU
// CondTrue      out    1  registered condition result
// StackEmpty    out    1  LIFO holds 0 entries
// StackFull     out    1  LIFO holds STACK_DEPTH entries
// StackError    out    1  sticky: push-when-full or pop-when-empty occurred
// BEHAVIOUR
// - Reset (async, Reset=0): Flags=0, CondTrue=0, stack count=0, StackEmpty=1,
//   StackFull=0, StackError=0, LIFO contents cleared; MainBus not driven.
// - Flags update priority per edge: Flags_Load=0 > Flags_Pop (legal) > AluActive.
//   Loser sources are ignored that cycle; no change if none active.
// - Load: Flags <= MainBus[4:0] sampled at the edge; bits[7:5] ignored.
// - Assert: MainBus = {3'b000,Flags} combinationally while Flags_Assert=0, else 'z.
//   Assert and Load together: Load captures the asserted (old) value -> no change.
// - Push: LIFO[count] <= Flags (pre-edge value), count+1. Pushed value is the value
//   before any same-cycle Flags update.
// - Pop: Flags <= LIFO[count-1], count-1; 1-cycle latency to Flags.
// - Push and Pop same cycle: net count unchanged; Flags <= old top, top <= old Flags
//   (swap). With count=0 this is pop-when-empty: push alone takes effect, error set.
// - Push with count=STACK_DEPTH: ignored, StackError<=1. Pop with count=0: ignored,
//   Flags follow the next priority source, StackError<=1.
// - StackError clears only on Reset. Count never wraps.
// - CondTrue registered from pre-edge Flags, 1-cycle latency; CondSel:
//   0 always, 1 Zero, 2 !Zero, 3 CarryA, 4 !CarryA, 5 Sign, 6 !Sign, 7 Overflow.
// - LCarryIn is combinational from the Flags register (no bypass of FlagsIn).
// - Reset asserted mid-push/pop aborts it; no partial LIFO write survives.
// TESTING
// - Reset=0 then release; AluActive=1, FlagsIn=5'b10101 -> next cycle Flags=5'b10101,
//   LCarryIn=1; CondSel=1 -> CondTrue=1 one cycle later.
// - Flags=5'h0A, Flags_Assert=0 -> MainBus=8'h0A; Flags_Assert=1 -> MainBus=8'hzz.
// - MainBus=8'hFF, Flags_Load=0, AluActive=1, FlagsIn=0 -> Flags=5'h1F (load wins).
// - Push 5'h01,5'h02,5'h03,5'h04 -> StackFull=1; 5th push -> StackError=1, count 4;
//   four pops -> Flags 5'h04,5'h03,5'h02,5'h01, StackEmpty=1.
// - Empty LIFO, Flags_Pop=1, AluActive=1, FlagsIn=5'h06 -> Flags=5'h06, StackError=1.
// - count=1 top=5'h11, Flags=5'h02, Push+Pop -> Flags=5'h11, top=5'h02, count=1;
//   Reset pulsed mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_flags_register.sv
// Architectural flags register sitting directly after the ALU.
// Captures ALU flags, exchanges them with MainBus, keeps a small LIFO of saved
// flags for interrupt entry/exit and registers the branch condition.
// Flag bit order everywhere: {CarryL, CarryA, Zero, Sign, Overflow}.
module alu_flags_register #(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       Clock,
  input  logic       Reset,        // asynchronous, active-low
  input  logic       AluActive,
  input  logic [4:0] FlagsIn,
  inout  wire  [7:0] MainBus,
  input  logic       Flags_Load,   // active-low
  input  logic       Flags_Assert, // active-low
  input  logic       Flags_Push,
  input  logic       Flags_Pop,
  input  logic [2:0] CondSel,
  output logic [4:0] Flags,
  output logic       LCarryIn,
  output logic       CondTrue,
  output logic       StackEmpty,
  output logic       StackFull,
  output logic       StackError
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(STACK_DEPTH);

  // Saved-flags LIFO and its occupancy (one extra bit so "full" is representable).
  logic [4:0]       r_stack [STACK_DEPTH];
  logic [PTR_W:0]   r_count;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [4:0]       w_flags_next;
  logic             w_cond;
  logic             w_unused_bus;

  // Upper bus bits carry no flag information.
  assign w_unused_bus = &{1'b0, MainBus[7:5]};

  // A pop needs an entry; a push needs room unless a legal pop frees the top
  // in the same cycle, in which case the two become a swap of Flags and top.
  assign w_pop_ok  = Flags_Pop && (r_count != '0);
  assign w_push_ok = Flags_Push && ((r_count != DEPTH_C) || w_pop_ok);
  assign w_top_idx = PTR_W'(r_count - 1'b1);
  assign w_wr_idx  = w_pop_ok ? w_top_idx : r_count[PTR_W-1:0];

  // Bus driver: old flags go out while asserted, so a simultaneous load is a no-op.
  assign MainBus = (!Flags_Assert) ? {3'b000, Flags} : 8'hzz;

  assign LCarryIn   = Flags[4];
  assign StackEmpty = (r_count == '0);
  assign StackFull  = (r_count == DEPTH_C);

  // Select the next flags value: bus load, then legal pop, then ALU capture.
  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    w_flags_next = Flags;
    if (!Flags_Load)     w_flags_next = MainBus[4:0];
    else if (w_pop_ok)   w_flags_next = r_stack[w_top_idx];
    else if (AluActive)  w_flags_next = FlagsIn;
  end

  // Branch condition evaluated on the current (pre-edge) flags.
  always_comb begin
    w_cond = 1'b0;
    case (CondSel)
      3'd0: w_cond = 1'b1;
      3'd1: w_cond = Flags[2];
      3'd2: w_cond = ~Flags[2];
      3'd3: w_cond = Flags[3];
      3'd4: w_cond = ~Flags[3];
      3'd5: w_cond = Flags[1];
      3'd6: w_cond = ~Flags[1];
      3'd7: w_cond = Flags[0];
      default: w_cond = 1'b0;
    endcase
  end

  // Flags, condition, occupancy and sticky error state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      Flags      <= '0;
      CondTrue   <= 1'b0;
      r_count    <= '0;
      StackError <= 1'b0;
    end else begin
      Flags    <= w_flags_next;
      CondTrue <= w_cond;
      r_count  <= r_count + {{PTR_W{1'b0}}, w_push_ok} - {{PTR_W{1'b0}}, w_pop_ok};
      if ((Flags_Push && !w_push_ok) || (Flags_Pop && !w_pop_ok))
        StackError <= 1'b1;
    end
  end

  // LIFO storage: write the pre-edge flags at the push (or swap) slot.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      // NOTE: the LIFO is small and must read as cleared after reset, so it is
      // reset like ordinary flops rather than left as uninitialised memory.
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (w_push_ok) begin
      r_stack[w_wr_idx] <= Flags;
    end
  end

endmodule

// File: tb/tb_alu_flags_register.sv
// Self-checking bench for alu_flags_register: directed scenarios followed by
// random stimulus, all compared against a queue-based reference model.
module tb_alu_flags_register;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       AluActive;
  logic [4:0] FlagsIn;
  wire  [7:0] MainBus;
  logic       Flags_Load;
  logic       Flags_Assert;
  logic       Flags_Push;
  logic       Flags_Pop;
  logic [2:0] CondSel;
  logic [4:0] Flags;
  logic       LCarryIn;
  logic       CondTrue;
  logic       StackEmpty;
  logic       StackFull;
  logic       StackError;

  logic       b_en;
  logic [7:0] b_val;
  assign MainBus = b_en ? b_val : 8'hzz;

  always #5 Clock = ~Clock;

  alu_flags_register #(.STACK_DEPTH(4), .PTR_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .AluActive(AluActive), .FlagsIn(FlagsIn),
    .MainBus(MainBus), .Flags_Load(Flags_Load), .Flags_Assert(Flags_Assert),
    .Flags_Push(Flags_Push), .Flags_Pop(Flags_Pop), .CondSel(CondSel),
    .Flags(Flags), .LCarryIn(LCarryIn), .CondTrue(CondTrue),
    .StackEmpty(StackEmpty), .StackFull(StackFull), .StackError(StackError)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [4:0] m_flags;
  logic [4:0] m_stack[$];
  logic       m_cond;
  logic       m_err;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_of(input logic [2:0] sel, input logic [4:0] f);
    logic carry_a, zero, sign, ovf;
    {carry_a, zero, sign, ovf} = f[3:0];
    case (sel)
      3'd0: return 1'b1;
      3'd1: return zero;
      3'd2: return !zero;
      3'd3: return carry_a;
      3'd4: return !carry_a;
      3'd5: return sign;
      3'd6: return !sign;
      default: return ovf;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "/flags"},  {3'b0, Flags},      {3'b0, m_flags});
    check({tag, "/lcarry"}, {7'b0, LCarryIn},   {7'b0, m_flags[4]});
    check({tag, "/cond"},   {7'b0, CondTrue},   {7'b0, m_cond});
    check({tag, "/empty"},  {7'b0, StackEmpty}, {7'b0, m_stack.size() == 0});
    check({tag, "/full"},   {7'b0, StackFull},  {7'b0, m_stack.size() == 4});
    check({tag, "/err"},    {7'b0, StackError}, {7'b0, m_err});
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_cond  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic idle_inputs();
    AluActive = 0; FlagsIn = '0; Flags_Load = 1; Flags_Assert = 1;
    Flags_Push = 0; Flags_Pop = 0; CondSel = '0; b_en = 1; b_val = 8'h00;
  endtask

  // One clock cycle: apply inputs mid-cycle, check the bus, advance model and DUT,
  // then check registered outputs at the next falling edge.
  task automatic step(input string tag, input logic alu, input logic [4:0] fin,
                      input logic ld_n, input logic as_n, input logic push,
                      input logic pop, input logic [2:0] sel, input logic [7:0] bus);
    logic [7:0] bus_now;
    logic [4:0] top;
    bit         pop_ok, push_ok;
    AluActive = alu; FlagsIn = fin; Flags_Load = ld_n; Flags_Assert = as_n;
    Flags_Push = push; Flags_Pop = pop; CondSel = sel;
    b_en = as_n; b_val = bus;
    #1;
    bus_now = as_n ? bus : {3'b000, m_flags};
    check({tag, "/bus"}, MainBus, bus_now);

    pop_ok  = pop && (m_stack.size() > 0);
    push_ok = push && ((m_stack.size() < 4) || pop_ok);
    m_err   = m_err | (push && !push_ok) | (pop && !pop_ok);
    m_cond  = cond_of(sel, m_flags);
    top     = pop_ok ? m_stack[$] : 5'h00;
    if (pop_ok)  void'(m_stack.pop_back());
    if (push_ok) m_stack.push_back(m_flags);
    if (!ld_n)        m_flags = bus_now[4:0];
    else if (pop_ok)  m_flags = top;
    else if (alu)     m_flags = fin;

    @(posedge Clock);
    @(negedge Clock);
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset = 0;
    #1;
    model_reset();
    check_state(tag);
    @(negedge Clock);
    idle_inputs();
    Reset = 1;
    #1;
    check_state({tag, "_rel"});
  endtask

  initial begin
    idle_inputs();
    Reset = 1;
    model_reset();
    @(negedge Clock);
    do_reset("reset");

    // ALU capture, carry-in and condition latency.
    step("alu10101", 1, 5'b10101, 1, 1, 0, 0, 3'd1, 8'h00);
    step("cond_zero", 0, 5'h00, 1, 1, 0, 0, 3'd1, 8'h00);

    // Bus load, assert, and release.
    step("load0a",   0, 5'h00, 0, 1, 0, 0, 3'd0, 8'h0A);
    step("assert0a", 0, 5'h00, 1, 0, 0, 0, 3'd2, 8'h00);
    step("release",  0, 5'h00, 1, 1, 0, 0, 3'd3, 8'h55);
    step("ld_and_as", 1, 5'h1C, 0, 0, 0, 0, 3'd4, 8'h00);
    step("load_wins", 1, 5'h00, 0, 1, 0, 0, 3'd5, 8'hFF);

    // Fill the LIFO, overflow it, then drain it.
    step("set01",  1, 5'h01, 1, 1, 0, 0, 3'd7, 8'h00);
    step("push01", 1, 5'h02, 1, 1, 1, 0, 3'd6, 8'h00);
    step("push02", 1, 5'h03, 1, 1, 1, 0, 3'd0, 8'h00);
    step("push03", 1, 5'h04, 1, 1, 1, 0, 3'd0, 8'h00);
    step("push04", 0, 5'h00, 1, 1, 1, 0, 3'd0, 8'h00);
    step("push5th", 0, 5'h00, 1, 1, 1, 0, 3'd0, 8'h00);
    step("pop04",  0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);
    step("pop03",  0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);
    step("pop02",  0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);
    step("pop01",  0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);

    // Pop on empty falls through to the ALU source.
    do_reset("reset2");
    step("pop_empty", 1, 5'h06, 1, 1, 0, 1, 3'd0, 8'h00);

    // Swap: count 1 with top 11, flags 02.
    do_reset("reset3");
    step("set11",  1, 5'h11, 1, 1, 0, 0, 3'd0, 8'h00);
    step("push11", 1, 5'h02, 1, 1, 1, 0, 3'd0, 8'h00);
    step("swap",   0, 5'h00, 1, 1, 1, 1, 3'd0, 8'h00);
    step("pop_sw", 0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);

    // Push+pop on empty: push alone lands, error set.
    do_reset("reset4");
    step("pp_empty", 1, 5'h09, 1, 1, 1, 1, 3'd0, 8'h00);
    step("pp_pop",   0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);

    // Reset mid-push must leave no stored entry behind.
    step("pre_push", 1, 5'h15, 1, 1, 0, 0, 3'd0, 8'h00);
    Flags_Push = 1;
    do_reset("mid_reset");
    step("after_rst_pop", 0, 5'h00, 1, 1, 0, 1, 3'd0, 8'h00);

    // Random traffic (bus load never combined with pop).
    do_reset("reset5");
    for (int n = 0; n < 400; n++) begin
      logic alu, ld_n, as_n, push, pop;
      logic [4:0] fin;
      logic [2:0] sel;
      logic [7:0] bus;
      alu  = 1'($urandom_range(0, 1));
      fin  = 5'($urandom);
      ld_n = ($urandom_range(0, 7) != 0);
      as_n = ($urandom_range(0, 3) != 0);
      push = ($urandom_range(0, 2) == 0);
      pop  = ($urandom_range(0, 2) == 0);
      sel  = 3'($urandom);
      bus  = 8'($urandom);
      if (!ld_n) pop = 0;
      step("rand", alu, fin, ld_n, as_n, push, pop, sel, bus);
      if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
